optical_tx_framer: RTL

Transmit-side framer that sits directly upstream of the optical line encoder. It accepts a raw payload byte stream and emits one framed packet per payload: SYNC byte, LEN byte, payload bytes, then a CRC-8 byte. The CRC is computed with the same CRC-8 configuration used on the receive side (poly 0x1D, init 0xFF, reflected in/out, xorout 0x00; CRC-8/AES), so the receiver's CRC over payload plus CRC byte is 0x00. Payload is buffered internally because LEN precedes the payload on the wire.

---
 rtl/optical_tx_framer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/optical_tx_framer.sv
// Transmit framer: buffers one payload, then emits SYNC, LEN, payload, CRC-8/AES.
// Fill and drain never overlap; the buffer is read combinationally so PAYLOAD has no bubble.
module optical_tx_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic       m_valid_o,
    output logic [7:0] m_data_o,
    output logic       m_last_o,
    input  logic       m_ready_i,
    output logic       truncated_o
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        FILL,
        SYNC,
        LEN,
        PAYLOAD,
        CRC
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] rd;
    logic [7:0] crc;
    logic [7:0] crc_nx;
    logic       trunc_q;
    logic       in_beat;
    logic       out_beat;
    logic       at_max;
    logic [7:0] mem [MAX_LEN];

    // Reflected CRC-8 (poly 0x1D -> 0xB8 reflected), one byte per call.
    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
        end
        return r;
    endfunction

    assign in_beat     = s_valid_i && (state == FILL);
    assign out_beat    = m_ready_i && (state != FILL);
    assign at_max      = (cnt == 8'(MAX_LEN - 1));
    assign crc_nx      = crc_upd(crc, s_data_i);
    assign truncated_o = trunc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        s_ready_o = 1'b0;
        m_valid_o = 1'b1;
        m_data_o  = 8'h00;
        m_last_o  = 1'b0;
        unique case (state)
            FILL: begin
                s_ready_o = 1'b1;
                m_valid_o = 1'b0;
                if (in_beat && (s_last_i || at_max)) begin
                    state_nx = SYNC;
                end
            end
            SYNC: begin
                m_data_o = SYNC_BYTE;
                if (out_beat) state_nx = LEN;
            end
            LEN: begin
                m_data_o = cnt;
                if (out_beat) state_nx = PAYLOAD;
            end
            PAYLOAD: begin
                m_data_o = mem[rd[AW-1:0]];
                if (out_beat && (rd == cnt - 8'd1)) state_nx = CRC;
            end
            CRC: begin
                m_data_o = crc;
                m_last_o = 1'b1;
                if (out_beat) state_nx = FILL;
            end
            default: begin
                state_nx  = FILL;
                m_valid_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= 8'd0;
            rd      <= 8'd0;
            crc     <= 8'hFF;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            if (in_beat) begin
                cnt     <= cnt + 8'd1;
                crc     <= crc_nx;
                trunc_q <= at_max && !s_last_i;
            end
            if (out_beat && state == LEN) begin
                rd <= 8'd0;
            end
            if (out_beat && state == PAYLOAD) begin
                rd <= rd + 8'd1;
            end
            if (out_beat && state == CRC) begin
                cnt <= 8'd0;
                crc <= 8'hFF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_beat) begin
            mem[cnt[AW-1:0]] <= s_data_i;
        end
    end

endmodule
